instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Front-end fetch stage that sits directly upstream of the processor's IF/ID pipeline register.
- Generates the word-indexed PC and issues reads to a synchronous instruction memory.
- Buffers returned words in a small prefetch FIFO and hands {pc, instr} to decode over a valid/ready handshake.
- Supports branch redirect with flush, and stops fetching on a HALT opcode.

Parameters:
- ADDR_W, 4: PC/instruction-memory address width in words; the PC wraps modulo 2^ADDR_W.
- FIFO_DEPTH, 4: prefetch buffer entries (power of two, >= 2).
- HALT_OP, 6'b111111: opcode in instr[31:26] that stops fetching.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0, released at 1).
- imem_rd_en  output  1  read strobe to instruction memory.
- imem_addr  output  ADDR_W  word address of the read.
- imem_rdata  input  32  read data, valid exactly one cycle after imem_rd_en.
- if_valid  output  1  FIFO head holds a valid instruction.
- if_ready  input  1  decode accepts the head this cycle.
- if_instr  output  32  head instruction ({opcode[31:26], rd[25:23], rs1[22:20], rs2[19:17], ...}).
- if_pc  output  ADDR_W  PC of the head instruction.
- redirect_valid  input  1  branch/jump redirect request.
- redirect_pc  input  ADDR_W  redirect target.
- halted  output  1  fetch stopped on HALT.

Behaviour:
- Reset (reset==0, asynchronous):
  - pc=0, FIFO empty, in-flight flag=0, state=IDLE.
  - Outputs: if_valid=0, if_instr=0, if_pc=0, imem_rd_en=0, imem_addr=0, halted=0.
- State machine IDLE -> FETCH -> HALTED:
  - IDLE: one cycle after reset release, no reads issued; moves to FETCH on the next edge.
  - FETCH: issues reads under the credit rule below.
  - HALTED: no reads; halted=1; the FIFO still drains to decode normally.
  - HALTED -> FETCH only on redirect_valid.
- Credit rule:
  - In FETCH, imem_rd_en=1 iff (occupancy + inflight) < FIFO_DEPTH and redirect_valid==0.
  - imem_addr=pc (combinational from the pc register).
  - On each issue: pc <= pc+1, wrapping 2^ADDR_W-1 -> 0; inflight <= 1 and tag <= pc are recorded.
  - The FIFO can therefore never overflow; there is no drop path.
- Return path: in the cycle after an issue, imem_rdata is pushed as {tag, imem_rdata} at the cycle-ending edge, unless discarded (see redirect and HALT).
- Latency:
  - First read (addr 0) occurs in the 2nd cycle after reset release.
  - if_valid first rises in the 4th cycle.
  - Steady state with if_ready=1 is one instruction per cycle.
- Output handshake:
  - if_valid = FIFO non-empty and redirect_valid==0.
  - Pop happens when if_valid && if_ready.
  - if_instr/if_pc show the head combinationally; both are 0 when the FIFO is empty.
  - Head contents stay stable while if_valid=1 and if_ready=0.
- Simultaneous push and pop: both take effect; occupancy is unchanged.
- HALT:
  - When a pushed word has opcode==HALT_OP, the word is still pushed, state goes to HALTED, and halted=1 from the next cycle.
  - Any read issued in the same cycle as that push is discarded when it returns.
  - pc keeps its post-increment value.
- Redirect (redirect_valid==1 in any state):
  - At the edge: FIFO cleared, any in-flight return discarded, pc <= redirect_pc, state <= FETCH, halted <= 0.
  - No read is issued and no pop occurs in the redirect cycle.
  - Redirect has priority over pop, push and HALT detection in the same cycle.
  - The first read at redirect_pc occurs in the following cycle.
- Reset asserted mid-operation: immediate return to the reset values above; an in-flight read is forgotten.

Test Plan:
- Reset release with imem[i]=32'h1000_0000+i, if_ready=1 -> if_valid rises in cycle 4 with if_pc=0, if_instr=32'h1000_0000; then one instruction per cycle with pc 1,2,3...
- if_ready=0 for 10 cycles -> exactly FIFO_DEPTH=4 entries buffered, imem_rd_en low once credits are exhausted, head held at pc 0. Release -> pc 0,1,2,3,4 delivered in order, none lost or duplicated.
- Free-run across the wrap -> after pc 15 the next if_pc is 0 with instr imem[0].
- imem[5] opcode=6'b111111 -> pc 0..5 delivered, halted=1, imem_rd_en stays 0, no pc 6 ever presented. Then redirect_pc=2 -> halted=0, next delivered if_pc=2.
- redirect_valid with 3 entries buffered, if_ready=1, redirect_pc=9 -> if_valid=0 that cycle; next delivered if_pc=9; the stale in-flight return is discarded.
- reset driven low while FIFO holds 2 entries and a read is in flight -> all outputs are 0 immediately; after release, the sequence restarts at pc 0 with reset-release timing.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues word reads to a synchronous instruction memory, buffers
// returned words in a prefetch FIFO and presents {pc, instr} to decode.
module instr_fetch_unit #(
    parameter int          ADDR_W     = 4,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [5:0]  HALT_OP    = 6'b111111
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  tag;
    logic               inflight;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               fifo_empty;
    logic               credit_ok;
    logic               push;
    logic               pop;
    logic               halt_word;
    logic [CNT_W-1:0]   committed;
    logic [ENTRY_W-1:0] head;

    // Credits cover both buffered entries and the read still on its way back.
    assign committed  = count + {{(CNT_W-1){1'b0}}, inflight};
    assign credit_ok  = committed < CNT_W'(FIFO_DEPTH);
    assign fifo_empty = (count == '0);
    assign halt_word  = (imem_rdata[31:26] == HALT_OP);
    assign imem_addr  = pc;

    assign head     = fifo_mem[rd_ptr];
    assign if_valid = !fifo_empty && !redirect_valid;
    assign if_instr = fifo_empty ? 32'd0 : head[31:0];
    assign if_pc    = fifo_empty ? '0 : head[ENTRY_W-1:32];
    assign pop      = if_valid && if_ready;

    always_comb begin
        state_next = state;
        imem_rd_en = 1'b0;
        halted     = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_rd_en = credit_ok && !redirect_valid;
                push       = inflight && !redirect_valid;
                if (push && halt_word) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                // A return arriving here was issued alongside the HALT word; drop it.
                halted = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (redirect_valid) begin
            state_next = FETCH;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= '0;
            tag      <= '0;
            inflight <= 1'b0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_rd_en;
            if (imem_rd_en) begin
                pc  <= pc + ADDR_W'(1);
                tag <= pc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {tag, imem_rdata};
        end
    end

endmodule
